multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle successor to the single-cycle `controller`. It sequences each RV32I-subset instruction over 3–5 cycles through a Moore-style state machine, driving the shared-memory datapath's mux selects and write enables. It adds memory wait states, optional `bne`, an illegal-instruction pulse, and a parametrised ALU control width. It sits between the instruction register and the multi-cycle datapath.

## Interface
- `ALU_CTRL_W`, default 3: width of `alu_control` (must be ≥3). Codes are zero-extended.
- `EN_BNE`, default 1: when set, funct3=001 on the branch opcode is accepted as `bne`.
- `clk` in 1: clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `op` in 7: opcode from the instruction register.
- `funct3` in 3: instruction funct3.
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register and OldPC enable.
- `result_src` out 2: result select (00 = ALUOut, 01 = Data, 10 = ALU result).
- `alu_src_a` out 2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1).
- `alu_src_b` out 2: ALU B select (00 = rs2, 01 = imm, 10 = constant 4).
- `imm_src` out 3: immediate format (I = 000, S = 001, B = 010, J = 011, U = 100).
- `reg_write` out 1: register file write enable.
- `alu_control` out `ALU_CTRL_W`: ALU operation code.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.

## Operation
- ALU codes: and = 000, or = 001, add = 010, lui-pass-B = 011, sub = 110, slt = 111.
- Supported opcodes: lw = 0000011, sw = 0100011, R = 0110011, I-ALU = 0010011, branch = 1100011, jal = 1101111, lui = 0110111.
- `imm_src` is decoded combinationally from `op` in every state. For unsupported opcodes it is 000.
- Unlisted outputs are 0 in each state. Default `alu_control` is add.
- FETCH:
  - Drives `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, add, `result_src` = 10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Next state is DECODE if `mem_ready`, else FETCH.
- DECODE:
  - Drives `alu_src_a` = 01, `alu_src_b` = 01, add. This computes the branch/jump target.
  - Next state by opcode:
    - lw/sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - jal → JAL
    - lui → LUI
  - On an unsupported op/funct3 combination: `illegal` = 1 and next state is FETCH.
- MEMADR:
  - Drives `alu_src_a` = 10, `alu_src_b` = 01, add.
  - Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: drives `adr_src` = 1. Stays until `mem_ready`, then goes to MEMWB.
- MEMWB: drives `result_src` = 01, `reg_write` = 1. Next state is FETCH.
- MEMWRITE: drives `adr_src` = 1, `mem_write` = 1, both held while waiting. Exits to FETCH on `mem_ready`.
- EXECR: drives `alu_src_a` = 10, `alu_src_b` = 00. ALU code per the table below. Next state is ALUWB.
- EXECI: drives `alu_src_a` = 10, `alu_src_b` = 01. ALU code per the table; `funct7b5` is ignored. Next state is ALUWB.
- ALUWB: drives `result_src` = 00, `reg_write` = 1. Next state is FETCH.
- BRANCH:
  - Drives `alu_src_a` = 10, `alu_src_b` = 00, sub, `result_src` = 00.
  - `pc_write` = `zero` for beq; `pc_write` = !`zero` for bne.
  - Next state is FETCH.
- JAL:
  - Drives `alu_src_a` = 01, `alu_src_b` = 10, add, `result_src` = 00, `pc_write` = 1.
  - Next state is ALUWB, which writes OldPC+4 to rd.
- LUI: drives `alu_src_b` = 01, code 011. Next state is ALUWB.
- ALU decode by funct3:
  - 000 → add. For R-type only, `funct7b5` = 1 selects sub.
  - 111 → and
  - 110 → or
  - 010 → slt
  - Any other funct3 is illegal.
- Legal branch funct3 is 000, plus 001 when `EN_BNE` = 1.

## Timing
- Reset:
  - At the `clk` edge with `reset` = 1, the state register loads FETCH.
  - While `reset` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0.
  - After reset, outputs take FETCH values. Reset asserted mid-instruction aborts it with no further writes.
- Outputs are combinational from the state plus `op`/`funct3`/`zero`/`mem_ready`. The state register is the only flop.
- Cycle counts with no wait states, including FETCH:
  - lw: 5
  - sw: 4
  - R: 4
  - I-ALU: 4
  - jal: 4
  - lui: 4
  - branch: 3
  - illegal: 2
- Each cycle of `mem_ready` = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While waiting, `mem_write` stays high in MEMWRITE and `adr_src` stays stable.
- `illegal` is high for exactly one cycle, in DECODE.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - the state enum,
  - opcode constants,
  - ALU code constants,
  - mux-select encodings for `result_src`, `alu_src_a`, `alu_src_b` and `imm_src`.
- Sub-module `alu_decoder` (combinational) maps op class, `funct3` and `funct7b5` to an ALU code plus a legal flag.
- The FSM lives in `multicycle_controller`.

## Test plan
- Reset high for 2 cycles, then `mem_ready` = 1 → FETCH outputs with `ir_write` = 1, `pc_write` = 1, `alu_src_b` = 10, `alu_control` = 010.
- lw (op 0000011), `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `reg_write` = 1 with `result_src` = 01 only in the last cycle.
- sub (op 0110011, funct3 000, funct7b5 = 1) → EXECR `alu_control` = 110; ALUWB `reg_write` = 1; 4 cycles.
- Branch funct3 001 with `zero` = 0 → `pc_write` = 1 in BRANCH when `EN_BNE` = 1. With `EN_BNE` = 0 → `illegal` pulse and no `pc_write` after FETCH.
- jal → JAL cycle has `pc_write` = 1 and `alu_src_a` = 01; next cycle `reg_write` = 1; `imm_src` = 011 throughout.
- sw with `reset` asserted in MEMWRITE while `mem_ready` = 0 → `mem_write` = 0 during reset; FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset controller.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned IMM_W      = 3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI
  } state_t;

  typedef enum logic {
    CLS_R,
    CLS_I
  } alu_class_t;

  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI = 3'b011;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode; unknown opcodes fall back to I.
  function automatic logic [IMM_W-1:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_SW:     imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      OP_LUI:    imm_sel = IMM_U;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decode for R-type and I-type ALU instructions.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_class_t                  cls,
  input  logic [2:0]                  funct3,
  input  logic                        funct7b5,
  output logic [ALU_CODE_W-1:0]       alu_code_c,
  output logic                        legal_c
);

  // funct7b5 only distinguishes sub from add on register-register ops.
  always_comb begin
    alu_code_c = ALU_ADD;
    legal_c    = 1'b1;
    case (funct3)
      3'b000:  alu_code_c = (cls == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_code_c = ALU_AND;
      3'b110:  alu_code_c = ALU_OR;
      3'b010:  alu_code_c = ALU_SLT;
      default: legal_c    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for the shared-memory multi-cycle RV32I-subset datapath.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          EN_BNE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_W-1:0]       op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [SEL_W-1:0]      result_src,
  output logic [SEL_W-1:0]      alu_src_a,
  output logic [SEL_W-1:0]      alu_src_b,
  output logic [IMM_W-1:0]      imm_src,
  output logic                  reg_write,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  if (ALU_CTRL_W < 3) begin : g_bad_width
    $error("ALU_CTRL_W must be at least 3");
  end

  state_t                  state;
  state_t                  state_next;
  alu_class_t              cls_c;
  logic [ALU_CODE_W-1:0]   dec_code_c;
  logic                    dec_legal_c;
  logic [ALU_CODE_W-1:0]   alu_code_c;
  logic                    branch_legal_c;

  assign cls_c          = (op == OP_R) ? CLS_R : CLS_I;
  assign branch_legal_c = (funct3 == 3'b000) || (EN_BNE && (funct3 == 3'b001));
  assign alu_control    = ALU_CTRL_W'(alu_code_c);

  alu_decoder u_alu_decoder (
    .cls        (cls_c),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_code_c (dec_code_c),
    .legal_c    (dec_legal_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    reg_write  = 1'b0;
    alu_code_c = ALU_ADD;
    illegal    = 1'b0;
    imm_src    = imm_sel(op);

    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      // Target PC (OldPC + imm) is formed here so branch/jal can use ALUOut.
      S_DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        state_next = S_FETCH;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         if (dec_legal_c) state_next = S_EXECR; else illegal = 1'b1;
          OP_I:         if (dec_legal_c) state_next = S_EXECI; else illegal = 1'b1;
          OP_BRANCH:    if (branch_legal_c) state_next = S_BRANCH; else illegal = 1'b1;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_code_c = dec_code_c;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_code_c = dec_code_c;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      // funct3[0] separates bne from beq; bne only reaches here when enabled.
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_code_c = ALU_SUB;
        pc_write   = funct3[0] ? ~zero : zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b  = SRCB_IMM;
        alu_code_c = ALU_LUI;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset suppresses every architectural write, even mid-instruction.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds the expected per-cycle control trace of each instruction and compares two controller instances.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
  logic [2:0] a_imm_src, a_alu_control;
  logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_illegal;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
  logic [2:0] b_imm_src;
  logic [3:0] b_alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  ctl_t trace[$];
  ctl_t exp_a[$];
  ctl_t exp_b[$];
  logic tplan[$];
  logic plan_q[$];

  multicycle_controller #(.ALU_CTRL_W(3), .EN_BNE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(a_pc_write), .adr_src(a_adr_src),
    .mem_write(a_mem_write), .ir_write(a_ir_write), .result_src(a_result_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .imm_src(a_imm_src),
    .reg_write(a_reg_write), .alu_control(a_alu_control), .illegal(a_illegal)
  );

  multicycle_controller #(.ALU_CTRL_W(4), .EN_BNE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(b_pc_write), .adr_src(b_adr_src),
    .mem_write(b_mem_write), .ir_write(b_ir_write), .result_src(b_result_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .imm_src(b_imm_src),
    .reg_write(b_reg_write), .alu_control(b_alu_control), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(logic pcw, logic adr, logic mw, logic irw, logic [1:0] rs,
                              logic [1:0] sa, logic [1:0] sb, logic rw, logic [2:0] alu, logic ill);
    ctl_t c;
    c = {pcw, adr, mw, irw, rs, sa, sb, rw, alu, ill};
    return c;
  endfunction

  function automatic logic [2:0] imm_ref(logic [6:0] o);
    case (o)
      SW:      return 3'b001;
      BR:      return 3'b010;
      JAL:     return 3'b011;
      LUI:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void push(ctl_t c, logic r);
    trace.push_back(c);
    tplan.push_back(r);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected whole-instruction trace from the instruction-level rules, with the mem_ready plan.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input bit bne_en, input int fw, input int mw);
    logic       legal;
    logic [2:0] code;
    trace.delete();
    tplan.delete();
    for (int i = 0; i <= fw; i++)
      push(mk(i == fw, 0, 0, i == fw, 2'b10, 2'b00, 2'b10, 0, 3'b010, 0), i == fw);
    legal = 1'b1;
    code  = 3'b010;
    if (o == RT || o == IT) begin
      case (f3)
        3'b000:  code = (o == RT && f7) ? 3'b110 : 3'b010;
        3'b111:  code = 3'b000;
        3'b110:  code = 3'b001;
        3'b010:  code = 3'b111;
        default: legal = 1'b0;
      endcase
    end else if (o == BR) begin
      legal = (f3 == 3'b000) || (bne_en && f3 == 3'b001);
    end else if (!(o == LW || o == SW || o == JAL || o == LUI)) begin
      legal = 1'b0;
    end
    push(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b010, !legal), rnd_bit());
    if (legal) begin
      case (o)
        LW: begin
          push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0), rnd_bit());
          for (int i = 0; i <= mw; i++)
            push(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0), i == mw);
          push(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b010, 0), rnd_bit());
        end
        SW: begin
          push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0), rnd_bit());
          for (int i = 0; i <= mw; i++)
            push(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0), i == mw);
        end
        RT, IT: begin
          push(mk(0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00, 0, code, 0), rnd_bit());
          push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0), rnd_bit());
        end
        BR: push(mk(f3[0] ? !z : z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b110, 0), rnd_bit());
        JAL: begin
          push(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0), rnd_bit());
          push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0), rnd_bit());
        end
        default: begin
          push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 3'b011, 0), rnd_bit());
          push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0), rnd_bit());
        end
      endcase
    end
  endtask

  task automatic run_cycles(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int n, input string name);
    ctl_t ga, gb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      mem_ready = plan_q[i];
      #2;
      ga = {a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_result_src, a_alu_src_a,
            a_alu_src_b, a_reg_write, a_alu_control, a_illegal};
      n_checks++;
      if ({a_imm_src, ga} !== {imm_ref(o), exp_a[i]}) begin
        n_fail++;
        $display("FAIL %s cycle %0d dut_a: got imm=%b ctl=%b, expected imm=%b ctl=%b",
                 name, i, a_imm_src, ga, imm_ref(o), exp_a[i]);
      end
      if (i < exp_b.size()) begin
        gb = {b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_result_src, b_alu_src_a,
              b_alu_src_b, b_reg_write, b_alu_control[2:0], b_illegal};
        n_checks++;
        if ({b_alu_control[3], b_imm_src, gb} !== {1'b0, imm_ref(o), exp_b[i]}) begin
          n_fail++;
          $display("FAIL %s cycle %0d dut_b: got alu3=%b imm=%b ctl=%b, expected alu3=0 imm=%b ctl=%b",
                   name, i, b_alu_control[3], b_imm_src, gb, imm_ref(o), exp_b[i]);
        end
      end
    end
  endtask

  task automatic check_reset_writes(input string name);
    n_checks++;
    if ({a_pc_write, a_ir_write, a_mem_write, a_reg_write, a_illegal,
         b_pc_write, b_ir_write, b_mem_write, b_reg_write, b_illegal} !== 10'b0) begin
      n_fail++;
      $display("FAIL %s: write enables during reset got a=%b b=%b, expected all 0", name,
               {a_pc_write, a_ir_write, a_mem_write, a_reg_write, a_illegal},
               {b_pc_write, b_ir_write, b_mem_write, b_reg_write, b_illegal});
    end
  endtask

  task automatic resync(input string name);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_reset_writes(name);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input int fw, input int mw, input string name);
    build(o, f3, f7, z, 1'b1, fw, mw);
    exp_a  = trace;
    plan_q = tplan;
    build(o, f3, f7, z, 1'b0, fw, mw);
    exp_b  = trace;
    run_cycles(o, f3, f7, z, exp_a.size(), name);
    if (exp_a.size() != exp_b.size()) resync({name, "_resync"});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = LUI;
    repeat (2) begin
      @(negedge clk);
      #2;
      check_reset_writes("reset_hold");
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, "reset_then_lui");
  endtask

  task automatic test_lw_wait();
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2, "lw_wait2");
    run_instr(LW, 3'b010, 1'b0, 1'b1, 2, 0, "lw_fetch_wait");
  endtask

  task automatic test_sub();
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, "sub");
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, "addi_f7_ignored");
    run_instr(RT, 3'b011, 1'b0, 1'b0, 0, 0, "r_illegal_f3");
  endtask

  task automatic test_branch();
    run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0, "bne_taken");
    run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0, "bne_not_taken");
    run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(BR, 3'b000, 1'b0, 1'b0, 1, 0, "beq_not_taken");
    run_instr(BR, 3'b100, 1'b0, 1'b0, 0, 0, "branch_illegal_f3");
  endtask

  task automatic test_jal();
    run_instr(JAL, 3'b101, 1'b1, 1'b0, 0, 0, "jal");
  endtask

  task automatic test_reset_mid_sw();
    build(SW, 3'b010, 1'b0, 1'b0, 1'b1, 0, 3);
    exp_a  = trace;
    exp_b  = trace;
    plan_q = tplan;
    run_cycles(SW, 3'b010, 1'b0, 1'b0, 4, "sw_before_abort");
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    #2;
    check_reset_writes("sw_abort");
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0, "or_after_abort");
  endtask

  task automatic test_random();
    logic [6:0] ops[8];
    logic [6:0] o;
    ops = '{LW, SW, RT, IT, BR, JAL, LUI, 7'd0};
    for (int k = 0; k < 150; k++) begin
      o = ops[$urandom_range(0, 7)];
      if (o == 7'd0) o = 7'($urandom);
      run_instr(o, 3'($urandom), rnd_bit(), rnd_bit(), $urandom_range(0, 2),
                $urandom_range(0, 2), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sub();
    test_branch();
    test_jal();
    test_reset_mid_sw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
